// File: rtl/regfile_rename_if.sv
// rtl/regfile_rename_if.sv - decoder/ROB-facing bundle for the renaming register file
//
// Ports (members):
//   rdy_in, flush_in                 pause / mispredict flush
//   ren_valid, ren_rd, ren_tag       rename (issue) write
//   cmt_valid, cmt_rd, cmt_tag,      ROB commit write
//   cmt_value
//   rd_id                            NUM_READ packed lookup ids
//   rd_busy, rd_value, rd_tag        NUM_READ packed lookup results
//   busy_count                       number of busy registers
// Modports: master drives requests, slave is the register file.
interface regfile_rename_if #(
    parameter int XLEN          = 32,
    parameter int REG_ID_BIT    = 5,
    parameter int ROB_WIDTH_BIT = 4,
    parameter int NUM_READ      = 2
) ();
    logic                              rdy_in;
    logic                              flush_in;
    logic                              ren_valid;
    logic [REG_ID_BIT-1:0]             ren_rd;
    logic [ROB_WIDTH_BIT-1:0]          ren_tag;
    logic                              cmt_valid;
    logic [REG_ID_BIT-1:0]             cmt_rd;
    logic [ROB_WIDTH_BIT-1:0]          cmt_tag;
    logic [XLEN-1:0]                   cmt_value;
    logic [NUM_READ*REG_ID_BIT-1:0]    rd_id;
    logic [NUM_READ-1:0]               rd_busy;
    logic [NUM_READ*XLEN-1:0]          rd_value;
    logic [NUM_READ*ROB_WIDTH_BIT-1:0] rd_tag;
    logic [REG_ID_BIT:0]               busy_count;

    modport master (
        output rdy_in, flush_in,
        output ren_valid, ren_rd, ren_tag,
        output cmt_valid, cmt_rd, cmt_tag, cmt_value,
        output rd_id,
        input  rd_busy, rd_value, rd_tag, busy_count
    );

    modport slave (
        input  rdy_in, flush_in,
        input  ren_valid, ren_rd, ren_tag,
        input  cmt_valid, cmt_rd, cmt_tag, cmt_value,
        input  rd_id,
        output rd_busy, rd_value, rd_tag, busy_count
    );
endinterface

// File: rtl/regfile_rename.sv
// rtl/regfile_rename.sv - architectural register file with rename busy/tag tracking
//
// Ports:
//   clk_in    clock, rising edge
//   rst_n_in  asynchronous active-low reset
//   rf        regfile_rename_if.slave: rename/commit writes, flush, pause,
//             NUM_READ combinational operand lookups, busy register count
module regfile_rename #(
    parameter int XLEN          = 32,
    parameter int NUM_REGS      = 32,
    parameter int REG_ID_BIT    = 5,
    parameter int ROB_WIDTH_BIT = 4,
    parameter int NUM_READ      = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    regfile_rename_if.slave  rf
);
    logic [XLEN-1:0]          regs [NUM_REGS];
    logic [ROB_WIDTH_BIT-1:0] tags [NUM_REGS];
    logic [NUM_REGS-1:0]      busy;
    logic [REG_ID_BIT:0]      count;

    logic                     cmt_do;
    logic                     cmt_clear;
    logic                     ren_do;
    logic                     cnt_inc;
    logic                     cnt_dec;

    // Write qualifiers; register 0 is excluded from every update.
    always_comb begin
        cmt_do    = rf.rdy_in && rf.cmt_valid && (rf.cmt_rd != '0);
        cmt_clear = cmt_do && busy[rf.cmt_rd] && (tags[rf.cmt_rd] == rf.cmt_tag);
        ren_do    = rf.rdy_in && rf.ren_valid && (rf.ren_rd != '0) && !rf.flush_in;
        // Renaming an already-busy register does not add a busy bit, and a
        // clearing commit to the register being renamed this cycle does not
        // remove one, since the rename keeps it busy.
        cnt_inc   = ren_do && !busy[rf.ren_rd];
        cnt_dec   = cmt_clear && !(ren_do && (rf.ren_rd == rf.cmt_rd));
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
                tags[i] <= '0;
            end
            busy  <= '0;
            count <= '0;
        end else if (rf.rdy_in) begin
            if (cmt_do) begin
                regs[rf.cmt_rd] <= rf.cmt_value;
            end
            if (rf.flush_in) begin
                busy  <= '0;
                count <= '0;
            end else begin
                // Rename is applied after the commit clear so it wins on a
                // shared register.
                if (cmt_clear) begin
                    busy[rf.cmt_rd] <= 1'b0;
                end
                if (ren_do) begin
                    busy[rf.ren_rd] <= 1'b1;
                    tags[rf.ren_rd] <= rf.ren_tag;
                end
                if (cnt_inc && !cnt_dec) begin
                    count <= count + 1'b1;
                end else if (cnt_dec && !cnt_inc) begin
                    count <= count - 1'b1;
                end
            end
        end
    end

    // Lookups see pre-update state, except that a tag-matching commit in the
    // same cycle is forwarded so the consumer does not wait an extra cycle.
    logic [REG_ID_BIT-1:0] id;

    always_comb begin
        rf.rd_busy  = '0;
        rf.rd_value = '0;
        rf.rd_tag   = '0;
        id          = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            id = rf.rd_id[i*REG_ID_BIT +: REG_ID_BIT];
            if (cmt_clear && (rf.cmt_rd == id)) begin
                rf.rd_value[i*XLEN +: XLEN] = rf.cmt_value;
            end else if (busy[id]) begin
                rf.rd_busy[i]                              = 1'b1;
                rf.rd_tag[i*ROB_WIDTH_BIT +: ROB_WIDTH_BIT] = tags[id];
            end else begin
                rf.rd_value[i*XLEN +: XLEN] = regs[id];
            end
        end
    end

    assign rf.busy_count = count;
endmodule

// File: tb/tb_regfile_rename.sv
// tb/tb_regfile_rename.sv - directed vector bench for regfile_rename
module tb_regfile_rename;
    localparam int XLEN = 32;
    localparam int NUM_REGS = 32;
    localparam int RB = 5;
    localparam int TB = 4;
    localparam int NR = 2;

    logic clk;
    logic rst_n;

    regfile_rename_if #(.XLEN(XLEN), .REG_ID_BIT(RB), .ROB_WIDTH_BIT(TB), .NUM_READ(NR)) rf ();

    regfile_rename #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .REG_ID_BIT(RB),
        .ROB_WIDTH_BIT(TB), .NUM_READ(NR)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .rf       (rf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        flush;
        logic        rv;
        logic [4:0]  rrd;
        logic [3:0]  rtag;
        logic        cv;
        logic [4:0]  crd;
        logic [3:0]  ctag;
        logic [31:0] cval;
        logic [4:0]  id0;
        logic [4:0]  id1;
        logic        eb0;
        logic [31:0] ev0;
        logic [3:0]  et0;
        logic        eb1;
        logic [31:0] ev1;
        logic [3:0]  et1;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t vecs [31];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic idle();
        rf.rdy_in    = 1'b1;
        rf.flush_in  = 1'b0;
        rf.ren_valid = 1'b0;
        rf.ren_rd    = '0;
        rf.ren_tag   = '0;
        rf.cmt_valid = 1'b0;
        rf.cmt_rd    = '0;
        rf.cmt_tag   = '0;
        rf.cmt_value = '0;
    endtask

    initial begin
        // rdy flush rv rrd rtag cv crd ctag cval | id0 id1 | eb0 ev0 et0 | eb1 ev1 et1 | cnt
        vecs[0]  = '{1,0,0, 0,0, 0, 0,0, 0,            5, 0, 0,0,0, 0,0,0, 0};
        vecs[1]  = '{1,0,1, 3,7, 0, 0,0, 0,            3, 0, 0,0,0, 0,0,0, 1};
        vecs[2]  = '{1,0,0, 0,0, 1, 3,7, 32'hDEADBEEF, 3, 3, 0,32'hDEADBEEF,0, 0,32'hDEADBEEF,0, 0};
        vecs[3]  = '{1,0,0, 0,0, 0, 0,0, 0,            3, 0, 0,32'hDEADBEEF,0, 0,0,0, 0};
        vecs[4]  = '{1,0,1, 3,2, 0, 0,0, 0,            3, 0, 0,32'hDEADBEEF,0, 0,0,0, 1};
        vecs[5]  = '{1,0,1, 3,5, 0, 0,0, 0,            3, 0, 1,0,2, 0,0,0, 1};
        vecs[6]  = '{1,0,0, 0,0, 1, 3,2, 32'h11,       3, 0, 1,0,5, 0,0,0, 1};
        vecs[7]  = '{1,0,0, 0,0, 0, 0,0, 0,            3, 0, 1,0,5, 0,0,0, 1};
        vecs[8]  = '{1,0,0, 0,0, 1, 3,5, 32'h22,       3, 0, 0,32'h22,0, 0,0,0, 0};
        vecs[9]  = '{1,0,1, 4,1, 0, 0,0, 0,            4, 0, 0,0,0, 0,0,0, 1};
        vecs[10] = '{1,0,1, 4,9, 1, 4,1, 32'h44,       4, 3, 0,32'h44,0, 0,32'h22,0, 1};
        vecs[11] = '{1,0,0, 0,0, 0, 0,0, 0,            4, 0, 1,0,9, 0,0,0, 1};
        vecs[12] = '{1,0,1, 1,1, 0, 0,0, 0,            1, 0, 0,0,0, 0,0,0, 2};
        vecs[13] = '{1,0,1, 2,2, 0, 0,0, 0,            2, 0, 0,0,0, 0,0,0, 3};
        vecs[14] = '{1,0,1, 6,3, 0, 0,0, 0,            1, 2, 1,0,1, 1,0,2, 4};
        vecs[15] = '{1,1,1, 7,4, 0, 0,0, 0,            6, 4, 1,0,3, 1,0,9, 0};
        vecs[16] = '{1,0,0, 0,0, 0, 0,0, 0,            7, 4, 0,0,0, 0,32'h44,0, 0};
        vecs[17] = '{1,0,0, 0,0, 0, 0,0, 0,            1, 6, 0,0,0, 0,0,0, 0};
        vecs[18] = '{1,0,1, 10,1, 0, 0,0, 0,           10, 0, 0,0,0, 0,0,0, 1};
        vecs[19] = '{1,0,0, 0,0, 1, 10,4, 32'h55,      10, 0, 1,0,1, 0,0,0, 1};
        vecs[20] = '{1,1,0, 0,0, 0, 0,0, 0,            10, 0, 1,0,1, 0,0,0, 0};
        vecs[21] = '{1,0,0, 0,0, 0, 0,0, 0,            10, 0, 0,32'h55,0, 0,0,0, 0};
        vecs[22] = '{1,0,1, 0,3, 1, 0,0, 32'h99,       0, 0, 0,0,0, 0,0,0, 0};
        vecs[23] = '{0,0,1, 8,3, 0, 0,0, 0,            8, 0, 0,0,0, 0,0,0, 0};
        vecs[24] = '{0,0,0, 0,0, 1, 3,0, 32'h77,       3, 0, 0,32'h22,0, 0,0,0, 0};
        vecs[25] = '{1,0,0, 0,0, 0, 0,0, 0,            8, 3, 0,0,0, 0,32'h22,0, 0};
        vecs[26] = '{1,0,1, 12,2, 0, 0,0, 0,           12, 0, 0,0,0, 0,0,0, 1};
        vecs[27] = '{1,0,1, 13,3, 1, 12,2, 32'hAB,     12, 13, 0,32'hAB,0, 0,0,0, 1};
        vecs[28] = '{1,0,0, 0,0, 0, 0,0, 0,            12, 13, 0,32'hAB,0, 1,0,3, 1};
        vecs[29] = '{1,0,1, 13,7, 0, 0,0, 0,           13, 0, 1,0,3, 0,0,0, 1};
        vecs[30] = '{1,0,0, 0,0, 0, 0,0, 0,            13, 0, 1,0,7, 0,0,0, 1};

        idle();
        rf.rd_id = {5'd0, 5'd5};
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", -1, 32'(rf.rd_busy), 32'd0);
        check("reset_value0", -1, rf.rd_value[31:0], 32'd0);
        check("reset_count", -1, 32'(rf.busy_count), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 31; i++) begin
            rf.rdy_in    = vecs[i].rdy;
            rf.flush_in  = vecs[i].flush;
            rf.ren_valid = vecs[i].rv;
            rf.ren_rd    = vecs[i].rrd;
            rf.ren_tag   = vecs[i].rtag;
            rf.cmt_valid = vecs[i].cv;
            rf.cmt_rd    = vecs[i].crd;
            rf.cmt_tag   = vecs[i].ctag;
            rf.cmt_value = vecs[i].cval;
            rf.rd_id     = {vecs[i].id1, vecs[i].id0};
            #1;
            check("busy0",  i, 32'(rf.rd_busy[0]), 32'(vecs[i].eb0));
            check("value0", i, rf.rd_value[31:0], vecs[i].ev0);
            check("tag0",   i, 32'(rf.rd_tag[3:0]), 32'(vecs[i].et0));
            check("busy1",  i, 32'(rf.rd_busy[1]), 32'(vecs[i].eb1));
            check("value1", i, rf.rd_value[63:32], vecs[i].ev1);
            check("tag1",   i, 32'(rf.rd_tag[7:4]), 32'(vecs[i].et1));
            @(posedge clk);
            #1;
            idle();
            check("count", i, 32'(rf.busy_count), 32'(vecs[i].ecnt));
        end

        // Asynchronous reset mid-cycle: x13 is busy with tag 7 here.
        rf.rd_id = {5'd12, 5'd13};
        #1;
        check("pre_reset_busy", 100, 32'(rf.rd_busy[0]), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_busy", 101, 32'(rf.rd_busy), 32'd0);
        check("async_tag", 101, 32'(rf.rd_tag), 32'd0);
        check("async_value1", 101, rf.rd_value[63:32], 32'd0);
        check("async_count", 101, 32'(rf.busy_count), 32'd0);

        // Commit and rename presented during reset must be ignored.
        rf.ren_valid = 1'b1;
        rf.ren_rd    = 5'd13;
        rf.ren_tag   = 4'd2;
        @(posedge clk);
        #1;
        check("reset_hold_busy", 102, 32'(rf.rd_busy), 32'd0);
        check("reset_hold_count", 102, 32'(rf.busy_count), 32'd0);
        idle();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end
endmodule

// File: doc/regfile_rename.md
Name: regfile_rename

Overview:
Parametrised architectural register file with rename-status tracking. It is the successor to the single-port register/status file. It serves NUM_READ combinational operand lookups per cycle for the decoder, one rename (issue) write, and one ROB commit write per cycle. Commits are tag-checked, there is a same-cycle commit bypass, a global flush, and a busy-register counter. It sits between the decoder/issue stage and the ROB commit path.

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers (register 0 is hardwired zero)
REG_ID_BIT, 5, register index width (clog2 NUM_REGS)
ROB_WIDTH_BIT, 4, ROB tag width
NUM_READ, 2, number of read (operand lookup) ports

Ports:
clk_in  input  1  clock, rising edge
rst_n_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  low = pause: all state frozen, reads still valid
flush_in  input  1  mispredict flush: clear all busy bits
ren_valid  input  1  rename request valid
ren_rd  input  REG_ID_BIT  destination register being renamed
ren_tag  input  ROB_WIDTH_BIT  ROB tag now owning ren_rd
cmt_valid  input  1  commit valid
cmt_rd  input  REG_ID_BIT  destination register committed
cmt_tag  input  ROB_WIDTH_BIT  ROB tag of committing entry
cmt_value  input  XLEN  committed value
rd_id  input  NUM_READ*REG_ID_BIT  lookup register ids, port i at slice i
rd_busy  output  NUM_READ  1 = value pending, tag valid
rd_value  output  NUM_READ*XLEN  register value; 0 when busy
rd_tag  output  NUM_READ*ROB_WIDTH_BIT  owning ROB tag; 0 when not busy
busy_count  output  REG_ID_BIT+1  number of currently busy registers

Behaviour:
- Reset (rst_n_in low, async): all regs, busy bits and tags to 0; busy_count 0. Lookup outputs then read 0/not-busy.
- Register 0: never busy, always reads 0; rename and commit to rd 0 are ignored, including the counter.
- Reads are combinational, evaluated per port i from state plus bypass:
  - If cmt_valid, rdy_in, cmt_rd == id != 0, busy[id] and tag[id] == cmt_tag: busy = 0, value = cmt_value, tag = 0 (commit bypass).
  - Else if busy[id]: busy = 1, value = 0, tag = tag[id].
  - Else: busy = 0, value = regs[id], tag = 0.
- Reads never see a same-cycle rename. Reads reflect pre-rename state so an instruction reading its own rd gets the old producer.
- Sequential updates happen on posedge, only when rdy_in is high. When rdy_in is low, nothing changes.
- Commit (cmt_valid, cmt_rd != 0): regs[cmt_rd] <= cmt_value always. busy[cmt_rd] is cleared only if busy and tag[cmt_rd] == cmt_tag; a stale tag updates the value only.
- Rename (ren_valid, ren_rd != 0, !flush_in): busy[ren_rd] <= 1, tag[ren_rd] <= ren_tag.
- Same register renamed and committed in one cycle: rename wins. The register ends busy with ren_tag, and the value is still written.
- flush_in: all busy bits cleared and the rename is dropped. A same-cycle commit still writes its value. busy_count <= 0.
- busy_count tracks the number of busy bits exactly:
  - +1 on a rename of a not-busy register.
  - -1 on a tag-matching commit with no same-reg rename.
  - Net 0 on rename and commit to the same register, or on a rename of an already-busy register.
  - Rename and clearing commit to different registers: net 0.
  - Never exceeds NUM_REGS-1.
- Reset mid-operation overrides all pending rename, commit and flush.

Test Plan:
- Reset, then read x5, x0 -> busy 0, value 0, tag 0; busy_count 0.
- Rename x3 tag 7; next cycle commit x3 tag 7 value 0xDEADBEEF -> during the commit cycle, port 0 on x3 reads busy 0, value 0xDEADBEEF (bypass); afterwards it persists; busy_count 1 then 0.
- Rename x3 tag 2, then rename x3 tag 5, then commit x3 tag 2 value 0x11 -> x3 remains busy, tag 5; stored value 0x11; busy_count stays 1.
- Same cycle: commit x4 tag 1 (x4 busy tag 1) and rename x4 tag 9 -> x4 busy, tag 9; busy_count unchanged. A same-cycle read of x4 returns bypassed value, busy 0.
- Rename x1, x2, x6; assert flush_in together with rename x7 -> all read busy 0, x7 not busy, busy_count 0.
- Hold rdy_in low while renaming x8 tag 3 -> x8 not busy. Assert rst_n_in low mid-cycle -> outputs 0 immediately, without a clock edge.
